fifo_wr_arbiter: RTL

//  Round-robin write-port arbiter for the shared shift-register FIFO (write/datain/full interface).

---
 rtl/fifo_wr_arbiter_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Imported by the arbiter top and its round-robin picker.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam int NREQ_DEF  = 4;
  localparam int DW_DEF    = 8;
  localparam int BURST_DEF = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: first set bit of v after p, wrapping, p last.
// Purely combinational; output is don't-care when v is zero.
module fifo_wr_arbiter_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         v,
  input  logic [$clog2(NREQ)-1:0] p,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  int         j;
  logic [IW-1:0] jj;

  // Scan farthest first so the nearest hit overwrites.
  always_comb begin
    idx = '0;
    j   = 0;
    jj  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j  = (int'(p) + k) % NREQ;
      jj = IW'(j);
      if (v[jj]) idx = jj;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of the shared FIFO.
// Grants one producer for up to BURST beats, then rotates.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int DATA_WIDTH = DW_DEF,
  parameter int BURST      = BURST_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_write,
  output logic [DATA_WIDTH-1:0]      fifo_datain,
  output logic [NREQ-1:0]            grant,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] data_a [NREQ];
  logic [IW-1:0]   pick, pick_p;
  logic [NREQ-1:0] pick_oh;
  logic            any_v, cur_v, busy_s;
  logic            accept, last_beat, rel;

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign data_a[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign any_v     = |req_valid;
  assign busy_s    = (state_q == ST_GRANT);
  assign cur_v     = req_valid[gid_q];
  assign accept    = busy_s & cur_v & ~fifo_full;
  assign last_beat = (cnt_q == CW'(BURST - 1));
  assign rel       = busy_s & (~cur_v | (accept & last_beat));

  // Handoff scans from the holder, so it ranks last.
  assign pick_p = busy_s ? gid_q : ptr_q;

  fifo_wr_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .v   (req_valid),
    .p   (pick_p),
    .idx (pick)
  );

  always_comb begin
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_v) begin
          state_d = ST_GRANT;
          gid_d   = pick;
          grant_d = pick_oh;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        if (accept) cnt_d = cnt_q + CW'(1);
        if (rel) begin
          ptr_d = gid_q;
          cnt_d = '0;
          if (any_v) begin
            gid_d   = pick;
            grant_d = pick_oh;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= IW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (busy_s && !fifo_full) req_ready[gid_q] = 1'b1;
  end

  assign fifo_write  = accept;
  assign fifo_datain = data_a[gid_q];
  assign grant       = grant_q;
  assign grant_id    = gid_q;
  assign busy        = busy_s;

endmodule
